// File: rtl/lu_seq_ctrl.sv
// lu_seq_ctrl: bit-serial sequencer around a shared 1-bit logic unit.
// A request latches two WIDTH-bit operands and a function code, then walks
// the operands LSB first through the external 1-bit LU (lu_a/lu_b/lu_sel
// out, lu_s back in). It collects one result bit per cycle into a shadow
// register and publishes the full word to result only at completion.
// Function code 111 is rejected: it goes straight to DONE with err=1.
//
// Optional feature: define LU_SEQ_CTRL_PARITY_EN to add result_par, the
// XOR-reduction of the value loaded into result.
//
// Handshake: start is sampled on every rising edge but is acted on only
// in IDLE; while busy=1 it is ignored and never queued. done is a
// one-cycle pulse in the DONE state, and err is only ever high with done.
module lu_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             lu_a,
  output logic             lu_b,
  output logic [2:0]       lu_sel,
  input  logic             lu_s,
`ifdef LU_SEQ_CTRL_PARITY_EN
  output logic             result_par,
`endif
  output logic [1:0]       dbg_state
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [2:0]    SEL_INV  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
`ifdef LU_SEQ_CTRL_PARITY_EN
  logic             par_q, par_d;
`endif

  // State register: reset returns to IDLE from anywhere, including mid-RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN for valid codes, IDLE -> DONE for the
  // invalid code, RUN -> DONE after the last bit, DONE -> IDLE always.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_sel == SEL_INV) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: status from the state, LU drive only while in RUN.
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    err    = (state_q == S_DONE) && err_q;
    result = result_q;
    lu_a   = 1'b0;
    lu_b   = 1'b0;
    lu_sel = 3'b000;
    if (state_q == S_RUN) begin
      lu_a   = a_q[idx_q];
      lu_b   = b_q[idx_q];
      lu_sel = sel_q;
    end
  end

  assign dbg_state = state_q;

  // Datapath next values: latch on accepted start, capture one LU bit per
  // RUN cycle, and publish the completed shadow word on the last bit.
  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef LU_SEQ_CTRL_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_sel == SEL_INV) begin
            // Rejected request: flag it, keep operands and result as they are.
            err_d = 1'b1;
          end else begin
            a_d   = op_a;
            b_d   = op_b;
            sel_d = op_sel;
            idx_d = '0;
            err_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        shadow_d[idx_q] = lu_s;
        if (idx_q == IDX_LAST) begin
          // shadow_d already holds the final bit, so result never sees a
          // partially assembled word.
          idx_d    = '0;
          result_d = shadow_d;
`ifdef LU_SEQ_CTRL_PARITY_EN
          par_d    = ^shadow_d;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers: everything clears asynchronously with rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 3'b000;
      shadow_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef LU_SEQ_CTRL_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef LU_SEQ_CTRL_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

`ifdef LU_SEQ_CTRL_PARITY_EN
  assign result_par = par_q;
`endif

endmodule

// File: tb/tb_lu_seq_ctrl.sv
// Testbench for lu_seq_ctrl (WIDTH=8): a reference 1-bit LU closes the
// loop on lu_s, a table of directed operations is applied in order, and
// hand-written sequences cover held start, invalid code and mid-RUN reset.
module tb_lu_seq_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_sel;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             lu_a;
  logic             lu_b;
  logic [2:0]       lu_sel;
  logic             lu_s;
  logic [1:0]       dbg_state;
`ifdef LU_SEQ_CTRL_PARITY_EN
  logic             result_par;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  lu_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sel    (op_sel),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_sel    (lu_sel),
    .lu_s      (lu_s),
`ifdef LU_SEQ_CTRL_PARITY_EN
    .result_par(result_par),
`endif
    .dbg_state (dbg_state)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference 1-bit logic unit shared by the sequencer.
  always_comb begin
    case (lu_sel)
      3'b000:  lu_s = ~lu_a;
      3'b001:  lu_s = lu_a & lu_b;
      3'b010:  lu_s = ~(lu_a & lu_b);
      3'b011:  lu_s = lu_a | lu_b;
      3'b100:  lu_s = ~(lu_a | lu_b);
      3'b101:  lu_s = lu_a ^ lu_b;
      3'b110:  lu_s = ~(lu_a ^ lu_b);
      default: lu_s = 1'b0;
    endcase
  end

  // Watchdog so the run always ends even if a wait goes wrong.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one operation; hold=1 keeps start high with changing operands
  // until done is seen, which the DUT must ignore.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                        input logic [7:0] exp_res, input logic exp_err, input logic hold,
                        input string tag);
    int cyc;
    int busy_cnt;
    int exp_lat;
    logic seen_done;
    exp_lat   = (sel == 3'b111) ? 1 : WIDTH + 1;
    cyc       = 0;
    busy_cnt  = 0;
    seen_done = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    op_sel = sel;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (sel != 3'b111 && cyc <= WIDTH) begin
        check($sformatf("%s_lu_a_%0d", tag, cyc - 1), 32'(lu_a), 32'(a[cyc-1]));
        check($sformatf("%s_lu_b_%0d", tag, cyc - 1), 32'(lu_b), 32'(b[cyc-1]));
        check($sformatf("%s_lu_sel_%0d", tag, cyc - 1), 32'(lu_sel), 32'(sel));
      end
      if (done) begin
        seen_done = 1'b1;
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_lu_idle_in_done"}, 32'({lu_a, lu_b, lu_sel}), 32'd0);
`ifdef LU_SEQ_CTRL_PARITY_EN
        check({tag, "_par"}, 32'(result_par), 32'(^exp_res));
`endif
      end else begin
        check({tag, "_err_without_done"}, 32'(err), 32'd0);
      end
      if (hold && !seen_done) begin
        start  = 1'b1;
        op_a   = a ^ 8'(cyc * 37);
        op_b   = 8'(cyc);
        op_sel = 3'(cyc);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_back_to_idle"}, 32'({busy, done, err}), 32'd0);
    check({tag, "_result_held"}, 32'(result), 32'(exp_res));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Directed table; invalid-code rows expect the previous result held.
    vecs[0]  = '{8'hA5, 8'h0F, 3'b001, 8'h05, 1'b0};  // AND
    vecs[1]  = '{8'hA5, 8'h0F, 3'b101, 8'hAA, 1'b0};  // XOR
    vecs[2]  = '{8'hA5, 8'h0F, 3'b000, 8'h5A, 1'b0};  // NOT a
    vecs[3]  = '{8'h00, 8'h00, 3'b100, 8'hFF, 1'b0};  // NOR
    vecs[4]  = '{8'h00, 8'h00, 3'b111, 8'hFF, 1'b1};  // invalid, keeps FF
    vecs[5]  = '{8'hA5, 8'h0F, 3'b010, 8'hFA, 1'b0};  // NAND
    vecs[6]  = '{8'hA5, 8'h0F, 3'b011, 8'hAF, 1'b0};  // OR
    vecs[7]  = '{8'h3C, 8'h5A, 3'b110, 8'h99, 1'b0};  // XNOR
    vecs[8]  = '{8'hFF, 8'h00, 3'b100, 8'h00, 1'b0};  // NOR all zero
    vecs[9]  = '{8'hC3, 8'h81, 3'b001, 8'h81, 1'b0};  // AND
    vecs[10] = '{8'h12, 8'h34, 3'b111, 8'h81, 1'b1};  // invalid, keeps 81

    rst_n  = 1'b1;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    op_sel = 3'b000;
    #2 rst_n = 1'b0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_lu", 32'({lu_a, lu_b, lu_sel}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
`ifdef LU_SEQ_CTRL_PARITY_EN
    check("reset_par", 32'(result_par), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp_res, vecs[i].exp_err,
             1'b0, $sformatf("vec%0d", i));
    end

    // start held high with changing operands during RUN.
    run_op(8'hA5, 8'h0F, 3'b001, 8'h05, 1'b0, 1'b1, "hold");

    // Reset at RUN cycle 4: everything clears at once, no done afterwards.
    @(negedge clk);
    start  = 1'b1;
    op_a   = 8'h3C;
    op_b   = 8'hA5;
    op_sel = 3'b101;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_lu", 32'({lu_a, lu_b, lu_sel}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_%0d", i), 32'({busy, done, err}), 32'd0);
      check($sformatf("abort_result_%0d", i), 32'(result), 32'd0);
    end
    run_op(8'h5A, 8'h3C, 3'b011, 8'h7E, 1'b0, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
